// File: rtl/reg_share_pkg.sv
// Shared constants for the register-sharing arbiter: FSM encoding, parameter defaults
// and a modulo-increment helper used for the round-robin pointer.
package reg_share_pkg;

  localparam int NREQ_DEF  = 4;
  localparam int WIDTH_DEF = 8;

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_GRANT = 1'b1;

  function automatic int wrap_inc(input int idx, input int n);
    return (idx == n - 1) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: finds the first set req bit scanning upward
// from ptr, wrapping modulo NREQ.
module rr_pick
  import reg_share_pkg::*;
#(
  parameter int NREQ = NREQ_DEF
) (
  input  logic [NREQ-1:0]         req,
  input  logic [$clog2(NREQ)-1:0] ptr,
  output logic                    valid,
  output logic [$clog2(NREQ)-1:0] idx
);

  localparam int PW = $clog2(NREQ);

  always_comb begin
    valid = 1'b0;
    idx   = '0;
    // Walk offsets from farthest to nearest so the closest hit to ptr wins.
    for (int off = NREQ - 1; off >= 0; off--) begin
      int k;
      k = (int'(ptr) + off) % NREQ;
      if (req[k]) begin
        valid = 1'b1;
        idx   = PW'(k);
      end
    end
  end

endmodule

// File: rtl/reg_share_arb.sv
// Round-robin arbiter guarding one shared register; each grant writes once and returns
// to IDLE. Define ARB_LOCK_EN to let a locked owner keep the grant across cycles.
module reg_share_arb
  import reg_share_pkg::*;
#(
  parameter int NREQ  = NREQ_DEF,
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NREQ-1:0]         req,
  input  logic [NREQ-1:0]         lock,
  input  logic [NREQ*WIDTH-1:0]   wdata,
  output logic [NREQ-1:0]         gnt,
  output logic [NREQ-1:0]         ack,
  output logic [WIDTH-1:0]        q,
  output logic [$clog2(NREQ)-1:0] owner,
  output logic                    busy
);

  localparam int PW = $clog2(NREQ);

  logic [0:0]       state_q, state_d;
  logic [PW-1:0]    ptr_q, ptr_d;
  logic [NREQ-1:0]  gnt_q, gnt_d;
  logic [PW-1:0]    owner_q, owner_d;
  logic [WIDTH-1:0] q_q, q_d;

  logic             pick_valid;
  logic [PW-1:0]    pick_idx;
  logic             lock_hold;
  logic             owner_req;

  rr_pick #(.NREQ(NREQ)) u_pick (
    .req   (req),
    .ptr   (ptr_q),
    .valid (pick_valid),
    .idx   (pick_idx)
  );

  assign owner_req = req[owner_q];

`ifdef ARB_LOCK_EN
  assign lock_hold = lock[owner_q];
`else
  logic unused_lock;
  assign unused_lock = ^lock;
  assign lock_hold   = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    gnt_d   = gnt_q;
    owner_d = owner_q;
    q_d     = q_q;
    case (state_q)
      ST_IDLE: begin
        if (pick_valid) begin
          state_d           = ST_GRANT;
          gnt_d             = '0;
          gnt_d[pick_idx]   = 1'b1;
          owner_d           = pick_idx;
        end
      end
      default: begin
        if (owner_req) q_d = wdata[int'(owner_q)*WIDTH +: WIDTH];
        // A withdrawn request also ends the grant, just without a write.
        if (!(owner_req && lock_hold)) begin
          state_d = ST_IDLE;
          gnt_d   = '0;
          ptr_d   = PW'(wrap_inc(int'(owner_q), NREQ));
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      ptr_q   <= '0;
      gnt_q   <= '0;
      owner_q <= '0;
      q_q     <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      gnt_q   <= gnt_d;
      owner_q <= owner_d;
      q_q     <= q_d;
    end
  end

  assign gnt   = gnt_q;
  assign owner = owner_q;
  assign q     = q_q;
  assign busy  = (state_q == ST_GRANT);
  assign ack   = (state_q == ST_GRANT) ? (gnt_q & req) : '0;

endmodule

// File: tb/tb_reg_share_arb.sv
// Directed bench for reg_share_arb (NREQ=4, WIDTH=8); the lock scenario runs when
// ARB_LOCK_EN is defined, otherwise the bench checks that lock is ignored.
module tb_reg_share_arb;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  req;
  logic [3:0]  lock;
  logic [31:0] wdata;
  logic [3:0]  gnt;
  logic [3:0]  ack;
  logic [7:0]  q;
  logic [1:0]  owner;
  logic        busy;

  int checks   = 0;
  int failures = 0;

  reg_share_arb #(.NREQ(4), .WIDTH(8)) dut (
    .clk   (clk),
    .reset (reset),
    .req   (req),
    .lock  (lock),
    .wdata (wdata),
    .gnt   (gnt),
    .ack   (ack),
    .q     (q),
    .owner (owner),
    .busy  (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  task automatic set_lane(input int i, input logic [7:0] v);
    wdata[i*8 +: 8] = v;
  endtask

  initial begin
    reset = 1'b0;
    req   = '0;
    lock  = '0;
    wdata = '0;
    #1;
    check("rst_q", 32'(q), 0);
    check("rst_gnt", 32'(gnt), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_ack", 32'(ack), 0);
    check("rst_owner", 32'(owner), 0);
    step();
    step();
    reset = 1'b1;

    // Single write from requester 2.
    step();
    req = 4'b0100;
    set_lane(2, 8'hA5);
    mid();
    check("sw_idle_busy", 32'(busy), 0);
    step();
    mid();
    check("sw_gnt", 32'(gnt), 32'h4);
    check("sw_ack", 32'(ack), 32'h4);
    check("sw_busy", 32'(busy), 1);
    check("sw_owner", 32'(owner), 2);
    step();
    req = 4'b1001;
    set_lane(3, 8'h33);
    set_lane(0, 8'h44);
    mid();
    check("sw_q", 32'(q), 32'hA5);
    check("sw_gnt_off", 32'(gnt), 0);
    check("sw_ack_off", 32'(ack), 0);

    // Wrap: pointer sits at 3, so requester 3 goes before requester 0.
    step();
    mid();
    check("wrap_gnt3", 32'(gnt), 32'h8);
    check("wrap_ack3", 32'(ack), 32'h8);
    step();
    req = 4'b0001;
    mid();
    check("wrap_q3", 32'(q), 32'h33);
    check("wrap_gap", 32'(gnt), 0);
    step();
    mid();
    check("wrap_gnt0", 32'(gnt), 32'h1);
    check("wrap_ack0", 32'(ack), 32'h1);
    step();
    req = 4'b0000;
    mid();
    check("wrap_q0", 32'(q), 32'h44);

    // Reset asserted in the middle of a grant aborts the pending write.
    step();
    req = 4'b0010;
    set_lane(1, 8'h77);
    step();
    mid();
    check("ra_gnt", 32'(gnt), 32'h2);
    reset = 1'b0;
    #1;
    check("ra_q", 32'(q), 0);
    check("ra_gnt0", 32'(gnt), 0);
    check("ra_busy", 32'(busy), 0);
    check("ra_ack", 32'(ack), 0);
    step();
    reset = 1'b1;
    req   = 4'b0000;
    mid();
    check("ra_q_hold", 32'(q), 0);

    // Fairness: all four requesting continuously, pointer restarted at 0.
    step();
    req = 4'b1111;
    for (int i = 0; i < 4; i++) set_lane(i, 8'(8'h10 + i));
    for (int g = 0; g < 5; g++) begin
      int e;
      e = g % 4;
      step();
      mid();
      check($sformatf("fair_gnt%0d", g), 32'(gnt), 32'(1 << e));
      check($sformatf("fair_ack%0d", g), 32'(ack), 32'(1 << e));
      step();
      mid();
      check($sformatf("fair_gap%0d", g), 32'(ack), 0);
      check($sformatf("fair_q%0d", g), 32'(q), 32'(8'h10 + e));
    end
    req = 4'b0000;

    // Withdrawal: requester 1 drops its request during its grant.
    step();
    req = 4'b0010;
    set_lane(1, 8'h99);
    set_lane(2, 8'hBB);
    step();
    req = 4'b0100;
    mid();
    check("wd_gnt", 32'(gnt), 32'h2);
    check("wd_ack", 32'(ack), 0);
    step();
    mid();
    check("wd_q", 32'(q), 32'h10);
    check("wd_busy", 32'(busy), 0);
    step();
    mid();
    check("wd_gnt2", 32'(gnt), 32'h4);
    check("wd_ack2", 32'(ack), 32'h4);
    step();
    req = 4'b0000;
    mid();
    check("wd_q2", 32'(q), 32'hBB);

`ifdef ARB_LOCK_EN
    // Locked owner 0 writes three cycles in a row; requester 1 waits.
    step();
    req  = 4'b0011;
    lock = 4'b0001;
    set_lane(0, 8'h11);
    set_lane(1, 8'h55);
    step();
    mid();
    check("lk_gnt", 32'(gnt), 32'h1);
    check("lk_ack1", 32'(ack), 32'h1);
    step();
    set_lane(0, 8'h22);
    mid();
    check("lk_q1", 32'(q), 32'h11);
    check("lk_ack2", 32'(ack), 32'h1);
    step();
    set_lane(0, 8'h33);
    mid();
    check("lk_q2", 32'(q), 32'h22);
    check("lk_ack3", 32'(ack), 32'h1);
    step();
    req  = 4'b0010;
    lock = 4'b0000;
    mid();
    check("lk_q3", 32'(q), 32'h33);
    check("lk_ack_end", 32'(ack), 0);
    step();
    mid();
    check("lk_idle", 32'(busy), 0);
    step();
    mid();
    check("lk_next", 32'(gnt), 32'h2);
    step();
    req = 4'b0000;
`else
    // Lock is ignored: a locked requester still gets exactly one cycle.
    step();
    req  = 4'b0001;
    lock = 4'b0001;
    set_lane(0, 8'h5A);
    step();
    mid();
    check("nl_gnt", 32'(gnt), 32'h1);
    step();
    mid();
    check("nl_busy", 32'(busy), 0);
    check("nl_q", 32'(q), 32'h5A);
    req  = 4'b0000;
    lock = 4'b0000;
`endif

    step();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/reg_share_arb.md
REG_SHARE_ARB -- requirements
Module: reg_share_arb

Interface
REQ-001 Parameter NREQ, default 4, SHALL set the number of requesters (2..8).
REQ-002 Parameter WIDTH, default 8, SHALL set the shared register width.
REQ-003 clk  input  1  SHALL be the single clock; all state SHALL update on its rising edge.
REQ-004 reset  input  1  SHALL be the asynchronous, active-low reset.
REQ-005 req  input  NREQ  SHALL carry per-requester write requests, level-held until ack.
REQ-006 lock  input  NREQ  SHALL carry per-requester hold-ownership flags; used only under ARB_LOCK_EN.
REQ-007 wdata  input  NREQ*WIDTH  SHALL carry flattened write data; requester i occupies bits [i*WIDTH +: WIDTH].
REQ-008 gnt  output  NREQ  SHALL be the registered one-hot grant, all-zero when idle.
REQ-009 ack  output  NREQ  SHALL be a one-hot, single-cycle pulse marking an accepted write.
REQ-010 q  output  WIDTH  SHALL be the shared register contents.
REQ-011 owner  output  clog2(NREQ)  SHALL hold the index of the current or last grantee.
REQ-012 busy  output  1  SHALL be high exactly while the FSM is in GRANT.

Function
REQ-013 FSM states SHALL be IDLE and GRANT only.
REQ-014 IDLE with any req bit high SHALL go to GRANT next cycle, with gnt/owner set to the first set req bit found scanning upward from ptr, wrapping modulo NREQ.
REQ-015 IDLE with req all-zero SHALL stay in IDLE with gnt zero.
REQ-016 In GRANT, with req[owner] high, q SHALL load wdata[owner] at the end of that cycle and ack[owner] SHALL be high during it.
REQ-017 Latency SHALL be: req sampled at edge N -> gnt from N+1 -> ack during cycle N+1 -> new q visible after edge N+2.
REQ-018 In GRANT, with req[owner] low (withdrawn), there SHALL be no write and no ack, and the FSM SHALL return to IDLE.
REQ-019 Leaving GRANT SHALL set ptr to (owner+1) mod NREQ, including on wrap from NREQ-1 to 0.
REQ-020 Without lock, each grant SHALL last exactly one cycle, giving at most one write per 2 cycles.
REQ-021 New requests arriving while in GRANT SHALL be held off and arbitrated from IDLE only.
REQ-022 ack SHALL be combinational from state, gnt and req; all other outputs SHALL be registered.

Reset
REQ-023 reset low SHALL immediately force: state=IDLE, ptr=0, gnt=0, owner=0, q=0, busy=0, ack=0.
REQ-024 Reset asserted during GRANT SHALL abort the write, leaving q=0.
REQ-025 The first arbitration after reset release SHALL favour requester 0.

Configuration
REQ-026 With macro ARB_LOCK_EN defined, GRANT with req[owner] and lock[owner] both high SHALL stay in GRANT, writing and acking every cycle; ptr SHALL advance only on exit.
REQ-027 With ARB_LOCK_EN undefined, the lock input SHALL be ignored and REQ-020 SHALL hold.

Structure
REQ-028 State encoding (IDLE=0, GRANT=1) and the NREQ/WIDTH defaults SHALL live in shared package reg_share_pkg.
REQ-029 Round-robin selection SHALL be a combinational sub-module rr_pick (inputs req, ptr; outputs valid, idx); the FSM and registers SHALL stay in reg_share_arb.

Verification
REQ-030 Reset check: assert reset mid-run -> q=0, gnt=0, busy=0 with no clock edge.
REQ-031 Single write: req=0100 with wdata[2]=8'hA5 -> gnt=0100 at N+1, ack[2] pulses once, q=8'hA5 after N+2.
REQ-032 Fairness: req=1111 held -> grant order 0,1,2,3,0, one ack each per 2 cycles.
REQ-033 Wrap: ptr=3 with req=1001 -> requester 3 granted, then requester 0.
REQ-034 Withdrawal: req[1] dropped during its GRANT -> no ack, q unchanged, next grant goes to requester 2 or later.
REQ-035 Lock (ARB_LOCK_EN): req[0]=lock[0]=1 for 3 cycles with wdata 11,22,33 -> three consecutive ack[0] pulses, q=33, then requester 1 granted.
